// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter
// Owns the single write port (A3/WE3/WD3) of the integer register file.
// Each cycle it merges one single-cycle ALU result or one buffered long-latency
// M-extension result into a registered write.
// It also keeps a pending-destination scoreboard that decode uses for hazard stalls.
// Optional feature macro: WB_FWD_EN. When defined, the block adds combinational
// write-port forwarding outputs, and HAZARD ignores any source being forwarded.
module regfile_writeback_arbiter #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            alu_valid_i,
    input  logic [4:0]      alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic            m_valid_i,
    output logic            m_ready_o,
    input  logic [4:0]      m_rd_i,
    input  logic [XLEN-1:0] m_data_i,
    input  logic            iss_valid_i,
    input  logic [4:0]      iss_rd_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    output logic            hazard_o,
    output logic [31:0]     pend_o,
    output logic            alu_stall_o,
    output logic [4:0]      a3_o,
    output logic            we3_o,
    output logic [XLEN-1:0] wd3_o
`ifdef WB_FWD_EN
    ,
    output logic            fwd1_valid_o,
    output logic [XLEN-1:0] fwd1_data_o,
    output logic            fwd2_valid_o,
    output logic [XLEN-1:0] fwd2_data_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [3:0]    STARVE_C = 4'(STARVE_LIM);

    logic [4:0]      fifo_rd_q   [DEPTH];
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      starve_q, starve_d;
    logic            stall_q, stall_d;
    logic [31:0]     pend_q, pend_d;
    logic [4:0]      a3_q, a3_d;
    logic            we3_q, we3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;

    logic fifo_ne, alu_win, pop, push;
    logic fwd1, fwd2;

    assign fifo_ne   = (count_q != '0);
    assign m_ready_o = (count_q < DEPTH_C);
    // A stall cycle ignores the ALU entirely; rd=0 ALU results never win the port.
    assign alu_win   = !stall_q && alu_valid_i && (alu_rd_i != 5'd0);
    assign pop       = fifo_ne && !alu_win;
    // Results aimed at x0 are accepted but never stored.
    assign push      = m_valid_i && m_ready_o && (m_rd_i != 5'd0);

    // Arbitration, FIFO bookkeeping, starvation counter and scoreboard next state
    always_comb begin
        a3_d     = a3_q;
        wd3_d    = wd3_q;
        we3_d    = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        pend_d   = pend_q;

        if (alu_win) begin
            we3_d = 1'b1;
            a3_d  = alu_rd_i;
            wd3_d = alu_data_i;
        end else if (pop) begin
            we3_d = 1'b1;
            a3_d  = fifo_rd_q[rd_ptr_q];
            wd3_d = fifo_data_q[rd_ptr_q];
        end

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Counts only cycles where a waiting head loses to the ALU.
        if (!fifo_ne || pop) starve_d = 4'd0;
        else                 starve_d = starve_q + 4'd1;
        stall_d = (starve_d == STARVE_C);

        // Clear on commit first so a same-edge set takes priority.
        if (we3_q) pend_d[a3_q] = 1'b0;
        if (iss_valid_i && (iss_rd_i != 5'd0)) pend_d[iss_rd_i] = 1'b1;
        pend_d[0] = 1'b0;
    end

    // State registers; reset drops FIFO contents and pending bits at once
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            pend_q   <= '0;
            a3_q     <= '0;
            we3_q    <= 1'b0;
            wd3_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            pend_q   <= pend_d;
            a3_q     <= a3_d;
            we3_q    <= we3_d;
            wd3_q    <= wd3_d;
        end
    end

    // M-result FIFO storage
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else if (push) begin
            fifo_rd_q[wr_ptr_q]   <= m_rd_i;
            fifo_data_q[wr_ptr_q] <= m_data_i;
        end
    end

`ifdef WB_FWD_EN
    assign fwd1 = we3_q && (a3_q == rs1_i) && (rs1_i != 5'd0);
    assign fwd2 = we3_q && (a3_q == rs2_i) && (rs2_i != 5'd0);
    assign fwd1_valid_o = fwd1;
    assign fwd2_valid_o = fwd2;
    assign fwd1_data_o  = wd3_q;
    assign fwd2_data_o  = wd3_q;
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign hazard_o    = (pend_q[rs1_i] && !fwd1) || (pend_q[rs2_i] && !fwd2);
    assign pend_o      = pend_q;
    assign alu_stall_o = stall_q;
    assign a3_o        = a3_q;
    assign we3_o       = we3_q;
    assign wd3_o       = wd3_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
module tb_regfile_writeback_arbiter;
    localparam int XLEN = 32;
    localparam int DEPTH = 2;
    localparam int LIM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            alu_valid, m_valid, iss_valid;
    logic [4:0]      alu_rd, m_rd, iss_rd, rs1, rs2;
    logic [XLEN-1:0] alu_data, m_data;
    logic            m_ready, hazard, alu_stall, we3;
    logic [31:0]     pend;
    logic [4:0]      a3;
    logic [XLEN-1:0] wd3;
`ifdef WB_FWD_EN
    logic            fwd1_valid, fwd2_valid;
    logic [XLEN-1:0] fwd1_data, fwd2_data;
`endif

    regfile_writeback_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
        .m_valid_i(m_valid), .m_ready_o(m_ready), .m_rd_i(m_rd), .m_data_i(m_data),
        .iss_valid_i(iss_valid), .iss_rd_i(iss_rd),
        .rs1_i(rs1), .rs2_i(rs2),
        .hazard_o(hazard), .pend_o(pend), .alu_stall_o(alu_stall),
        .a3_o(a3), .we3_o(we3), .wd3_o(wd3)
`ifdef WB_FWD_EN
        , .fwd1_valid_o(fwd1_valid), .fwd1_data_o(fwd1_data)
        , .fwd2_valid_o(fwd2_valid), .fwd2_data_o(fwd2_data)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: FIFO as a queue, the starvation rule as a plain loss count.
    typedef struct { logic [4:0] rd; logic [XLEN-1:0] d; } m_ent_t;
    m_ent_t          mq[$];
    logic            s_we, s_stall;
    logic [4:0]      s_a3;
    logic [XLEN-1:0] s_wd;
    logic [31:0]     s_pend;
    int              s_lost;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        s_we = 0; s_stall = 0; s_a3 = 0; s_wd = 0; s_pend = 0; s_lost = 0;
    endtask

    task automatic check_all();
        logic h1, h2;
        h1 = (rs1 != 0) && s_pend[rs1];
        h2 = (rs2 != 0) && s_pend[rs2];
`ifdef WB_FWD_EN
        if (s_we && s_a3 == rs1) h1 = 0;
        if (s_we && s_a3 == rs2) h2 = 0;
        chk("fwd1_valid", fwd1_valid, s_we && s_a3 == rs1 && rs1 != 0);
        chk("fwd2_valid", fwd2_valid, s_we && s_a3 == rs2 && rs2 != 0);
`endif
        chk("we3", we3, s_we);
        chk("a3", a3, s_a3);
        chk("wd3", wd3, s_wd);
        chk("alu_stall", alu_stall, s_stall);
        chk("m_ready", m_ready, mq.size() < DEPTH);
        chk("pend", pend, s_pend);
        chk("hazard", hazard, h1 || h2);
    endtask

    task automatic model_next();
        bit          alu_w, had, popd, pushd;
        logic [31:0] np;
        m_ent_t      e;
        alu_w = !s_stall && alu_valid && alu_rd != 0;
        had   = mq.size() > 0;
        popd  = !alu_w && had;
        pushd = m_valid && (mq.size() < DEPTH) && m_rd != 0;
        np = s_pend;
        if (s_we) np[s_a3] = 1'b0;
        if (iss_valid && iss_rd != 0) np[iss_rd] = 1'b1;
        if (alu_w) begin
            s_we = 1; s_a3 = alu_rd; s_wd = alu_data;
        end else if (popd) begin
            e = mq.pop_front();
            s_we = 1; s_a3 = e.rd; s_wd = e.d;
        end else begin
            s_we = 0;
        end
        if (pushd) begin
            e.rd = m_rd; e.d = m_data;
            mq.push_back(e);
        end
        s_lost  = (had && !popd) ? s_lost + 1 : 0;
        s_stall = (s_lost == LIM);
        s_pend  = np;
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic step();
        #1;
        check_all();
        model_next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        m_valid = 0; m_rd = 0; m_data = 0;
        iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        chk("rst_we3", we3, 0);
        chk("rst_pend", pend, 0);
        chk("rst_m_ready", m_ready, 1);
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 1;
        idle_inputs();
        @(negedge clk);

        // Reset while an ALU result is presented; it is written the cycle after release
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        do_reset();
        step();
        chk("alu_we3", we3, 1);
        chk("alu_a3", a3, 5);
        chk("alu_wd3", wd3, 32'h1234);

        // rd=0 ALU result is dropped
        alu_rd = 0; alu_data = 32'hFFFF;
        step();
        chk("x0_we3", we3, 0);
        alu_valid = 0;
        step();

        // M op to x7: issue, then result arrives with no ALU traffic
        iss_valid = 1; iss_rd = 7;
        step();
        iss_valid = 0; rs1 = 7;
        #1 chk("haz7_set", hazard, 1);
        m_valid = 1; m_rd = 7; m_data = 32'hDEAD;
        step();
        m_valid = 0;
        chk("m_lat_n1", we3, 0);
        step();
        chk("m_we3", we3, 1);
        chk("m_a3", a3, 7);
        chk("m_wd3", wd3, 32'hDEAD);
        chk("pend7_during_we", pend[7], 1);
        #1 chk("haz7_during_we", hazard, 1);
        step();
        chk("pend7_cleared", pend[7], 0);
        #1 chk("haz7_cleared", hazard, 0);
        rs1 = 0;

        // Continuous ALU traffic with two M pushes: starvation stall
        for (int c = 0; c < 8; c++) begin
            alu_valid = 1; alu_rd = 5'(10 + c); alu_data = 32'(c);
            m_valid = (c < 2); m_rd = 5'(20 + c); m_data = 32'(32'hA0 + c);
            #1;
            if (c == 2) chk("full_not_ready", m_ready, 0);
            if (c == 4) chk("no_stall_yet", alu_stall, 0);
            if (c == 5) chk("stall_pulse", alu_stall, 1);
            if (c == 6) begin
                chk("stall_head_a3", a3, 20);
                chk("stall_head_wd3", wd3, 32'hA0);
                chk("stall_one_cycle", alu_stall, 0);
            end
            step();
        end
        idle_inputs();
        repeat (3) step();

        // Same-edge issue and commit to x9: the set wins
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        step();
        alu_valid = 0; iss_valid = 1; iss_rd = 9;
        chk("x9_commit", a3, 9);
        step();
        iss_valid = 0;
        chk("pend9_set_wins", pend[9], 1);

`ifdef WB_FWD_EN
        // Forwarding hides a pending source that is on the write port this cycle
        iss_valid = 1; iss_rd = 3;
        step();
        iss_valid = 0; alu_valid = 1; alu_rd = 3; alu_data = 32'hABCD;
        step();
        alu_valid = 0; rs2 = 3;
        #1;
        chk("fwd2_valid_c", fwd2_valid, 1);
        chk("fwd2_data_c", fwd2_data, 32'hABCD);
        chk("fwd_hazard_c", hazard, 0);
        step();
        rs2 = 0;
`endif

        // Randomized traffic against the model, with one reset mid-run
        for (int i = 0; i < 400; i++) begin
            logic [4:0] cand;
            if (i == 200) do_reset();
            alu_valid = ($urandom_range(0, 9) < 7);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            m_valid   = ($urandom_range(0, 9) < 4);
            m_rd      = 5'($urandom_range(0, 31));
            m_data    = $urandom;
            cand      = 5'($urandom_range(0, 31));
            iss_valid = ($urandom_range(0, 3) == 0) && !s_pend[cand];
            iss_rd    = cand;
            rs1       = 5'($urandom_range(0, 31));
            rs2       = 5'($urandom_range(0, 31));
            step();
        end
        idle_inputs();
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_writeback_arbiter.md
# regfile_writeback_arbiter

- Owns the single write port of the RV32I/M integer register file.
- Merges single-cycle ALU results with long-latency M-extension (multiply/divide) results into one registered write per cycle.
- Keeps a pending-destination scoreboard so decode stalls on operands a long-latency op has not yet written.
- Sits between execute and the register file, driving its `A3`/`WE3`/`WD3` inputs.

## Interface
- `XLEN`, 32, datapath width.
- `DEPTH`, 2, M-result FIFO entries; power of two, ≥2.
- `STARVE_LIM`, 4, cycles a non-empty FIFO head may lose arbitration before ALU is stalled; 1–15.
- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `ALU_VALID` in 1: ALU result present this cycle.
- `ALU_RD` in 5: ALU destination.
- `ALU_DATA` in XLEN: ALU result.
- `M_VALID` in 1: M result offered.
- `M_READY` out 1: FIFO can accept.
- `M_RD` in 5: M destination.
- `M_DATA` in XLEN: M result.
- `ISS_VALID` in 1: an M op issued this cycle.
- `ISS_RD` in 5: its destination.
- `RS1`, `RS2` in 5 each: decode source indices.
- `HAZARD` out 1: combinational, a source is pending.
- `PEND` out 32: scoreboard; bit 0 constant 0.
- `ALU_STALL` out 1: registered; upstream must hold its ALU result.
- `A3` out 5, `WE3` out 1, `WD3` out XLEN: registered register-file write port.

## Operation
- Arbitration, evaluated each cycle:
  - `ALU_STALL=1`: FIFO head if non-empty, else nothing. `ALU_VALID` is ignored; upstream re-presents it.
  - Otherwise: ALU if `ALU_VALID` and `ALU_RD≠0`; else FIFO head if non-empty.
  - Winner is registered into `A3`/`WD3` with `WE3=1`; no winner → `WE3=0`, `A3`/`WD3` hold.
  - `ALU_VALID` with `ALU_RD=0` is consumed and dropped, never written.
- FIFO:
  - `M_READY = (count < DEPTH)`, from current count only. A full FIFO is not ready even in a pop cycle.
  - Push on `M_VALID && M_READY`. `M_RD=0` is accepted and discarded (no push).
  - Push into an empty FIFO is poppable from the next cycle; no same-cycle bypass.
  - Pointers wrap modulo `DEPTH`. Simultaneous push and pop keeps count unchanged.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and the ALU wins; resets on any FIFO pop or when the FIFO is empty.
  - Counter reaches `STARVE_LIM` → `ALU_STALL=1` for exactly the next cycle, then the counter clears.
- Scoreboard:
  - `ISS_VALID && ISS_RD≠0` sets `PEND[ISS_RD]`.
  - A clock edge with `WE3=1` clears `PEND[A3]`, i.e. clearing happens on the edge the register file commits.
  - Set and clear of the same index on the same edge: set wins.
  - `HAZARD = PEND[RS1] | PEND[RS2]`; index 0 never hazards.
  - Decode must not issue an M op whose `ISS_RD` is already pending.

## Timing
- Reset: `WE3=0`, `A3=0`, `WD3=0`, `ALU_STALL=0`, `PEND=0`, FIFO empty (`M_READY=1`), starvation counter 0.
- Reset asserted mid-operation discards FIFO contents and pending bits immediately.
- ALU latency: result presented in cycle n → `WE3` in n+1 → committed at end of n+1.
- M latency: accepted in cycle n → `WE3` no earlier than n+2.
- Worst-case M wait behind continuous ALU traffic: `STARVE_LIM+1` cycles per entry.
- `HAZARD` and `PEND` stay high for `A3` through the cycle in which `WE3=1` (data not yet in the file).

## Configuration
- `WB_FWD_EN` defined:
  - Adds outputs `FWD1_VALID`/`FWD1_DATA` and `FWD2_VALID`/`FWD2_DATA` (1 / XLEN bits), combinational.
  - `FWDx_VALID = WE3 && A3==RSx && RSx≠0`; `FWDx_DATA = WD3`.
  - `HAZARD` excludes a source whose `FWDx_VALID=1`.
- Undefined: ports absent; `HAZARD` as in Operation.

## Test plan
- Reset with `ALU_VALID=1` → all outputs at reset values; after release, `ALU_RD=5`, `ALU_DATA=0x1234` → next cycle `WE3=1`, `A3=5`, `WD3=0x1234`.
- `ALU_RD=0`, `ALU_DATA=0xFFFF` → `WE3` stays 0.
- `ISS_RD=7`, later `M_RD=7`, `M_DATA=0xDEAD` with no ALU traffic → `WE3` 2 cycles after accept; `PEND[7]` and `HAZARD` (`RS1=7`) clear one edge after `WE3`.
- Continuous ALU writes plus 2 M pushes, `STARVE_LIM=4` → `M_READY=0` at count 2; `ALU_STALL` pulses after 4 lost cycles; M head written during the stall.
- Same-edge `ISS_RD=9` and commit of `A3=9` → `PEND[9]` remains 1.
- With `WB_FWD_EN`: `WE3=1`, `A3=3`, `WD3=0xABCD`, `PEND[3]=1`, `RS2=3` → `FWD2_VALID=1`, `FWD2_DATA=0xABCD`, `HAZARD=0`.
